// File: rtl/ram_bank_pkg.sv
// ram_bank_pkg: shared types, default geometry and helpers for the RAM bank.
// Optional feature: RAM_BANK_BYPASS_EN selects write-first behaviour for
// same-cycle read and write in ram_bank. It is read-first when undefined.
package ram_bank_pkg;

  // Clear sequencer states: sweeping the array, or serving the host
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  // Number of byte lanes in a data word
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_bank_if.sv
// ram_bank_if: host-side bus of the RAM bank (access, clear request, results).
interface ram_bank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();
  import ram_bank_pkg::*;

  localparam int BE_W = be_width(DATA_W);

  logic              init;
  logic              clr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dat_in;
  logic [BE_W-1:0]   mem_be;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] mem_dat_out;
  logic              rd_valid;
  logic              busy;

  modport master (
    output init, clr, mem_addr, mem_dat_in, mem_be, wr, rd,
    input  mem_dat_out, rd_valid, busy
  );

  modport slave (
    input  init, clr, mem_addr, mem_dat_in, mem_be, wr, rd,
    output mem_dat_out, rd_valid, busy
  );

endinterface

// File: rtl/ram_bank_clear_seq.sv
// ram_bank_clear_seq: clear FSM and sweep counter. After reset or a clr
// pulse it walks addresses 0..DEPTH-1, one word per cycle, then goes idle.
module ram_bank_clear_seq
  import ram_bank_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] count, count_next;

  // State and sweep counter registers; reset always restarts the sweep at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state, counter advance and the clear write port
  always_comb begin
    state_next = state;
    count_next = count;
    busy       = 1'b0;
    clr_we     = 1'b0;
    clr_addr   = count;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr) begin
          count_next = '0;
        end else if (count == LAST_ADDR) begin
          count_next = '0;
          state_next = IDLE;
        end else begin
          count_next = count + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          count_next = '0;
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = CLEAR;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/ram_bank.sv
// ram_bank: parametrised single-port synchronous RAM with byte enables,
// registered reads with a valid strobe and a hardware clear sweep.
// Macro RAM_BANK_BYPASS_EN: same-address read and write returns the newly
// written bytes (write-first); without it the old word is returned.
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int                       DATA_W    = DEF_DATA_W,
  parameter int                       ADDR_W    = DEF_ADDR_W,
  parameter int                       DEPTH     = DEF_DEPTH,
  parameter logic [DATA_W-1:0]        CLEAR_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  ram_bank_if.slave bus
);

  localparam int BE_W = be_width(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range;
  logic              host_wr;
  logic              host_rd;
  logic [DATA_W-1:0] read_word;

  ram_bank_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  // Host access qualification; the host is locked out while clearing or in reset
  always_comb begin
    in_range = ({1'b0, bus.mem_addr} < DEPTH_EXT);
    host_wr  = ~rst & ~busy & bus.init & bus.wr & in_range;
    host_rd  = ~rst & ~busy & bus.init & bus.rd;
  end

  // Word presented to the read register, with optional same-cycle write merge
  always_comb begin
    read_word = '0;
    if (in_range) begin
      read_word = mem[bus.mem_addr];
`ifdef RAM_BANK_BYPASS_EN
      if (host_wr) begin
        for (int i = 0; i < BE_W; i++) begin
          if (bus.mem_be[i]) read_word[8*i +: 8] = bus.mem_dat_in[8*i +: 8];
        end
      end
`endif
    end
  end

  // Array write: clear sweep has priority, host writes update enabled bytes only
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VAL;
    end else if (host_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.mem_be[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_dat_in[8*i +: 8];
      end
    end
  end

  // Read register and valid strobe; data holds when no read is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_dat_out <= '0;
      bus.rd_valid    <= 1'b0;
    end else if (host_rd) begin
      bus.mem_dat_out <= read_word;
      bus.rd_valid    <= 1'b1;
    end else begin
      bus.rd_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: directed self-checking bench for ram_bank (DEPTH 256 and 200).
module tb_ram_bank;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ram_bank_if #(.DATA_W(16), .ADDR_W(8)) bus ();
  ram_bank_if #(.DATA_W(16), .ADDR_W(8)) bus_small ();

  ram_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .CLEAR_VAL(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ram_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .CLEAR_VAL(16'h0000)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_small.slave)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic init, input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [15:0] din,
                               input logic [1:0] be, input logic clr);
    bus.init       = init;
    bus.rd         = rd;
    bus.wr         = wr;
    bus.mem_addr   = addr;
    bus.mem_dat_in = din;
    bus.mem_be     = be;
    bus.clr        = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Counts sampled cycles with busy high, bounded so a stuck busy still ends
  task automatic countBusy(output int cycles);
    cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!bus.busy) break;
      cycles++;
      tick();
    end
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr,
                           input logic [15:0] expected);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 16'h0000, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, addr, 16'h0000, 2'b00, 1'b0);
    checkOutput({tag, "_data"}, {16'h0, bus.mem_dat_out}, {16'h0, expected});
    checkOutput({tag, "_valid"}, {31'h0, bus.rd_valid}, 32'h1);
    tick();
    checkOutput({tag, "_valid_drop"}, {31'h0, bus.rd_valid}, 32'h0);
  endtask

  task automatic writeWord(input logic [7:0] addr, input logic [15:0] din,
                           input logic [1:0] be);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, din, be, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, addr, 16'h0000, 2'b00, 1'b0);
  endtask

  initial begin
    int   cycles;
    logic saw_valid;
    n_checks = 0;
    n_fail   = 0;
    bus_small.init = 1'b1; bus_small.rd = 1'b0; bus_small.wr = 1'b0;
    bus_small.mem_addr = 8'h00; bus_small.mem_dat_in = 16'h0000;
    bus_small.mem_be = 2'b00; bus_small.clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0);

    // Reset values
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset_dout", {16'h0, bus.mem_dat_out}, 32'h0);
    checkOutput("reset_valid", {31'h0, bus.rd_valid}, 32'h0);
    checkOutput("reset_busy", {31'h0, bus.busy}, 32'h1);

    // Clear sweep after reset lasts DEPTH cycles
    countBusy(cycles);
    checkOutput("reset_busy_cycles", cycles, 256);
    checkOutput("small_idle", {31'h0, bus_small.busy}, 32'h0);

    readCheck("rd_00", 8'h00, 16'h0000);
    readCheck("rd_7f", 8'h7F, 16'h0000);
    readCheck("rd_ff", 8'hFF, 16'h0000);

    // Byte enables
    writeWord(8'h10, 16'hBEEF, 2'b01);
    readCheck("be_low", 8'h10, 16'h00EF);
    writeWord(8'h10, 16'h1234, 2'b10);
    readCheck("be_high", 8'h10, 16'h12EF);

    // Same-cycle read and write to one address
    writeWord(8'h20, 16'hAAAA, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 16'h5555, 2'b11, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 16'h0000, 2'b00, 1'b0);
`ifdef RAM_BANK_BYPASS_EN
    checkOutput("rw_same", {16'h0, bus.mem_dat_out}, 32'h5555);
`else
    checkOutput("rw_same", {16'h0, bus.mem_dat_out}, 32'hAAAA);
`endif
    checkOutput("rw_same_valid", {31'h0, bus.rd_valid}, 32'h1);
    tick();
    readCheck("rw_after", 8'h20, 16'h5555);

    // Back-to-back reads, then hold
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000, 2'b00, 1'b0);
    tick();
    checkOutput("b2b_first", {16'h0, bus.mem_dat_out}, 32'h12EF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 16'h0000, 2'b00, 1'b0);
    checkOutput("b2b_second", {16'h0, bus.mem_dat_out}, 32'h5555);
    checkOutput("b2b_valid", {31'h0, bus.rd_valid}, 32'h1);
    tick();
    checkOutput("hold_data", {16'h0, bus.mem_dat_out}, 32'h5555);
    checkOutput("hold_valid", {31'h0, bus.rd_valid}, 32'h0);

    // Write with no byte enables still serves the read
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 16'hFFFF, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000, 2'b00, 1'b0);
    checkOutput("be0_read", {16'h0, bus.mem_dat_out}, 32'h12EF);
    tick();
    readCheck("be0_after", 8'h10, 16'h12EF);

    // init low ignores host access
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h05, 16'h7777, 2'b11, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h05, 16'h0000, 2'b00, 1'b0);
    checkOutput("init0_valid", {31'h0, bus.rd_valid}, 32'h0);
    tick();
    readCheck("init0_mem", 8'h05, 16'h0000);

    // Out-of-range on the 200-word bank; last in-range word still works
    bus_small.wr = 1'b1; bus_small.mem_addr = 8'hF0;
    bus_small.mem_dat_in = 16'hFFFF; bus_small.mem_be = 2'b11;
    tick();
    bus_small.mem_addr = 8'hC7; bus_small.mem_dat_in = 16'h4321;
    tick();
    bus_small.wr = 1'b0; bus_small.rd = 1'b1; bus_small.mem_addr = 8'hF0;
    tick();
    checkOutput("oor_data", {16'h0, bus_small.mem_dat_out}, 32'h0);
    checkOutput("oor_valid", {31'h0, bus_small.rd_valid}, 32'h1);
    bus_small.mem_addr = 8'hC7;
    tick();
    bus_small.rd = 1'b0;
    checkOutput("last_word", {16'h0, bus_small.mem_dat_out}, 32'h4321);

    // Clear request, restart at cycle 100 with host traffic during busy
    writeWord(8'h7F, 16'hCAFE, 2'b11);
    readCheck("pre_clr_7f", 8'h7F, 16'hCAFE);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b1);
    tick();
    checkOutput("clr_busy", {31'h0, bus.busy}, 32'h1);
    saw_valid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h30, 16'h1111, 2'b11, 1'b0);
    for (int i = 1; i < 100; i++) begin
      tick();
      if (bus.rd_valid) saw_valid = 1'b1;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h30, 16'h1111, 2'b11, 1'b1);
    tick();
    if (bus.rd_valid) saw_valid = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h30, 16'h1111, 2'b11, 1'b0);
    tick();
    if (bus.rd_valid) saw_valid = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h30, 16'h0000, 2'b00, 1'b0);
    countBusy(cycles);
    checkOutput("restart_busy_cycles", cycles + 1, 256);
    checkOutput("busy_no_valid", {31'h0, saw_valid}, 32'h0);
    readCheck("clr_target", 8'h30, 16'h0000);
    readCheck("clr_7f", 8'h7F, 16'h0000);

    // Reset asserted during a read
    writeWord(8'h7F, 16'hCAFE, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h7F, 16'h0000, 2'b00, 1'b0);
    tick();
    checkOutput("pre_rst_read", {16'h0, bus.mem_dat_out}, 32'hCAFE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0);
    checkOutput("rst_mid_dout", {16'h0, bus.mem_dat_out}, 32'h0);
    checkOutput("rst_mid_valid", {31'h0, bus.rd_valid}, 32'h0);
    checkOutput("rst_mid_busy", {31'h0, bus.busy}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
